// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - operand/result handshake bundle for the bit-serial adder
interface bit_serial_adder_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         busy;

   modport master (
      output in_valid, a, b, carry_in, out_ready,
      input  in_ready, out_valid, sum, carry_out, busy
   );

   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
      output in_ready, out_valid, sum, carry_out, busy
   );
endinterface

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial W-bit adder built on one full_adder cell
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module bit_serial_adder #(
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   bit_serial_adder_if.slave bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_sr_q, a_sr_d;
   logic [W-1:0]  b_sr_q, b_sr_d;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fa_s, fa_c;

   full_adder u_fa (
      .a_i (a_sr_q[0]),
      .b_i (b_sr_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.carry_in;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sr_d       = a_sr_q >> 1;
            b_sr_d       = b_sr_q >> 1;
            res_d        = res_q >> 1;
            res_d[W-1]   = fa_s;
            carry_d      = fa_c;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Result is copied into a separate holding register so the
               // visible sum stays stable while the next operation shifts.
               sum_d   = res_d;
               cout_d  = fa_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
endmodule
